// File: rtl/one_byte_uart_rx_if.sv
// Receive-side bundle of the one-byte UART link.
// master drives the serial line, slave is the receiver.
interface one_byte_uart_rx_if;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx_in,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );
endinterface

// File: rtl/one_byte_uart_rx.sv
// 8N1 UART receiver: mid-bit start check, centre sampling,
// one-cycle valid / framing-error strobes.
module one_byte_uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int BAUD_CNT  = CLK_FREQ / BAUD_RATE
) (
    input  logic               clk,
    input  logic               rst_n,
    one_byte_uart_rx_if.slave  io_rx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [15:0] C_HALF_M1 = 16'(BAUD_CNT / 2 - 1);
    localparam logic [15:0] C_BIT_M1  = 16'(BAUD_CNT - 1);

    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [7:0]  r_data;
    logic [7:0]  w_data_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_ferr;
    logic        w_ferr_nxt;
    logic        w_start;

    // Flops reset high so a reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= io_rx.rx_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_start = r_s3 & ~r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (w_start) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == C_HALF_M1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == C_BIT_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_s2, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == C_BIT_M1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (r_s2) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                    end
                end
            end
        endcase
    end

    assign io_rx.rx_data      = r_data;
    assign io_rx.rx_valid     = r_valid;
    assign io_rx.rx_frame_err = r_ferr;
    assign io_rx.rx_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_one_byte_uart_rx.sv
// Bench for one_byte_uart_rx at BAUD_CNT=8: directed table,
// hand-written corner sequences, random line against a model.
module tb_one_byte_uart_rx;
    localparam int B = 8;
    localparam int H = B / 2;
    localparam int FB = H + 9 * B;

    typedef struct {
        int         p;
        int         kind;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        bit         stop;
        int         gap;
        int         kind;
        logic [7:0] xd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int busy_n = 0;
    int pcnt = 0;
    int wbase = 0;
    int exp_busy = 0;
    bit rec = 1'b0;
    bit wave[$];
    ev_t ev_q[$];
    ev_t exp_q[$];

    one_byte_uart_rx_if bus ();

    one_byte_uart_rx #(.BAUD_CNT(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_rx (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcnt++;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rx_busy) busy_n++;
        if (bus.rx_valid || bus.rx_frame_err) begin
            chk("pulse_excl", int'(bus.rx_valid & bus.rx_frame_err), 0);
            ev_q.push_back('{pcnt - 1, bus.rx_valid ? 1 : 2, bus.rx_data});
        end
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_in = v;
            if (rec) begin
                if (wave.size() == 0) wbase = pcnt;
                wave.push_back(v);
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input bit stop,
                        input int pe, input int po);
        for (int b = 0; b < 10; b++) begin
            bit v;
            v = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
            drive(v, (b % 2 == 0) ? pe : po);
        end
    endtask

    // Decode the recorded line from its sample points only.
    function automatic void run_model();
        int j;
        int k;
        logic [7:0] d;
        logic [7:0] last;
        j = 1;
        last = 8'h00;
        exp_q.delete();
        exp_busy = 0;
        while (j < wave.size()) begin
            if (wave[j-1] && !wave[j]) begin
                k = j;
                if (k + FB >= wave.size()) break;
                if (wave[k+H]) begin
                    exp_busy += H;
                    j = k + H + 1;
                end else begin
                    for (int n = 0; n < 8; n++) d[n] = wave[k+H+(n+1)*B];
                    if (wave[k+FB]) begin
                        last = d;
                        exp_q.push_back('{wbase + k + 2 + FB, 1, d});
                    end else begin
                        exp_q.push_back('{wbase + k + 2 + FB, 2, last});
                    end
                    exp_busy += FB;
                    j = k + FB + 1;
                end
            end else begin
                j++;
            end
        end
    endfunction

    task automatic expect_one(input string nm, input int m,
                              input int kind, input logic [7:0] d);
        chk({nm, "_n"}, ev_q.size() - m, 1);
        if (ev_q.size() > m) begin
            chk({nm, "_kind"}, ev_q[m].kind, kind);
            chk({nm, "_data"}, int'(ev_q[m].data), int'(d));
        end
    endtask

    initial begin
        vec_t tv[5];
        int obs[5];
        int m;
        int mode;
        logic [7:0] rd;

        tv[0] = '{8'hA5, 1'b1, 4, 1, 8'hA5};
        tv[1] = '{8'h00, 1'b1, 0, 1, 8'h00};
        tv[2] = '{8'hFF, 1'b1, 4, 1, 8'hFF};
        tv[3] = '{8'h5A, 1'b1, 3, 1, 8'h5A};
        tv[4] = '{8'h3C, 1'b0, 0, 2, 8'h5A};

        bus.rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", int'(bus.rx_data), 0);
        chk("rst_valid", int'(bus.rx_valid), 0);
        chk("rst_ferr", int'(bus.rx_frame_err), 0);
        chk("rst_busy", int'(bus.rx_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 6);

        m = ev_q.size();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            if (i > 0) obs[i-1] = busy_n;
            busy_n = 0;
            send(tv[i].d, tv[i].stop, B, B);
            drive(1'b1, tv[i].gap);
        end
        @(posedge clk);
        obs[4] = busy_n;
        chk("tbl_n", ev_q.size() - m, 5);
        for (int i = 0; i < 5; i++) begin
            chk("tbl_busy", obs[i], FB);
            if (m + i < ev_q.size()) begin
                chk("tbl_kind", ev_q[m+i].kind, tv[i].kind);
                chk("tbl_data", int'(ev_q[m+i].data), int'(tv[i].xd));
            end
        end

        busy_n = 0;
        m = ev_q.size();
        drive(1'b0, 40);
        @(posedge clk);
        chk("low_busy", busy_n, 0);
        chk("low_events", ev_q.size() - m, 0);
        drive(1'b1, 12);

        drive(1'b0, 4 * B);
        drive(1'b1, 3);
        #1;
        chk("midrst_busy_pre", int'(bus.rx_busy), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_data", int'(bus.rx_data), 0);
        chk("midrst_valid", int'(bus.rx_valid), 0);
        chk("midrst_ferr", int'(bus.rx_frame_err), 0);
        chk("midrst_busy", int'(bus.rx_busy), 0);
        busy_n = 0;
        m = ev_q.size();
        drive(1'b1, 2);
        rst_n = 1'b1;
        drive(1'b1, 45);
        @(posedge clk);
        chk("midrst_tail_busy", busy_n, 0);
        chk("midrst_tail_ev", ev_q.size() - m, 0);
        m = ev_q.size();
        send(8'hC3, 1'b1, B, B);
        drive(1'b1, 4);
        @(posedge clk);
        expect_one("after_rst", m, 1, 8'hC3);

        busy_n = 0;
        m = ev_q.size();
        drive(1'b0, 2);
        drive(1'b1, 14);
        @(posedge clk);
        chk("glitch_busy", busy_n, H);
        chk("glitch_ev", ev_q.size() - m, 0);

        m = ev_q.size();
        send(8'h96, 1'b1, 7, 9);
        drive(1'b1, 6);
        @(posedge clk);
        expect_one("tol_79", m, 1, 8'h96);
        m = ev_q.size();
        send(8'h96, 1'b1, 9, 7);
        drive(1'b1, 6);
        @(posedge clk);
        expect_one("tol_97", m, 1, 8'h96);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4);
        @(posedge clk);
        busy_n = 0;
        m = ev_q.size();
        rec = 1'b1;
        drive(1'b1, 4);
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                drive(1'b0, $urandom_range(1, 3));
                drive(1'b1, $urandom_range(2, 8));
            end else begin
                rd = 8'($urandom);
                mode = $urandom_range(0, 3);
                send(rd, $urandom_range(0, 4) != 0,
                     (mode == 0) ? 7 : (mode == 1) ? 9 : B,
                     (mode == 0) ? 9 : (mode == 1) ? 7 : B);
                drive(1'b1, $urandom_range(0, 4));
            end
        end
        drive(1'b1, 120);
        rec = 1'b0;
        @(posedge clk);
        run_model();
        chk("rnd_n", ev_q.size() - m, exp_q.size());
        chk("rnd_busy", busy_n, exp_busy);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (m + i < ev_q.size()) begin
                chk("rnd_cycle", ev_q[m+i].p, exp_q[i].p);
                chk("rnd_kind", ev_q[m+i].kind, exp_q[i].kind);
                chk("rnd_data", int'(ev_q[m+i].data), int'(exp_q[i].data));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
